mux_nx1_pipe: RTL and testbench

//  Parametrised N-input, WIDTH-bit multiplexer with a registered output and

---
 rtl/mux_nx1_pipe.sv | 99 +++++++++
 tb/tb_mux_nx1_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_pipe.sv
// N-input, WIDTH-bit multiplexer with a one-entry registered output stage.
// A channel is picked either by an explicit select or by a round-robin scan
// starting at a rotating pointer. The chosen channel's word is captured into
// the output register when the stage is empty or being drained this cycle.
//
// Handshake semantics (all ports): a word moves across an interface on a
// rising edge where valid and ready are both 1. A producer holds valid and
// data stable until that happens. in_ready is combinational from out_ready,
// sel, rr_mode, the rr pointer and (in round-robin mode only) in_valid.
// A sink must therefore not derive out_ready from in_ready.
module mux_nx1_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               rr_mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  // One extra bit so ptr + offset can exceed N-1 before wrapping.
  localparam int PW = SEL_W + 1;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] chosen;
  logic [SEL_W-1:0] ptr_next;
  logic [PW-1:0]    probe;
  logic             hit;
  logic             can_load;
  logic             transfer;
  logic [WIDTH-1:0] chosen_word;

  // Channel choice: explicit select, or first requester scanning from ptr.
  // The round-robin loop runs from the farthest offset down to offset 0 so
  // the last hit written is the one closest to ptr.
  always_comb begin
    hit    = 1'b0;
    chosen = '0;
    probe  = '0;
    if (!rr_mode) begin
      hit    = (int'(sel) < N);
      chosen = sel;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        probe = {1'b0, ptr} + PW'(k);
        if (probe >= PW'(N)) begin
          probe = probe - PW'(N);
        end
        if (in_valid[probe[SEL_W-1:0]]) begin
          hit    = 1'b1;
          chosen = probe[SEL_W-1:0];
        end
      end
    end
  end

  // Stage can take a word when empty or emptying; never during reset so a
  // reset cycle completes no handshake on either side.
  assign can_load = !rst && (!out_valid || out_ready);

  // Only the chosen channel sees ready; explicit mode ignores in_valid here.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = can_load && hit && (int'(chosen) == i);
    end
  end

  assign transfer    = can_load && hit && in_valid[chosen];
  assign chosen_word = in_data[int'(chosen) * WIDTH +: WIDTH];
  assign ptr_next    = (int'(chosen) == N - 1) ? '0 : chosen + SEL_W'(1);

  // Output register and rr pointer: load on transfer, clear valid on a
  // drain without reload, hold everything on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= chosen_word;
      out_ch    <= chosen;
      ptr       <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe (WIDTH=8, N=4): directed vector table, hand-written
// stall/reset sequences, then randomized traffic against a reference model.
module tb_mux_nx1_pipe;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk;
  logic               rst;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               rr_mode;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_ch;
  logic               out_valid;
  logic               out_ready;

  mux_nx1_pipe #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Model of the output register contents and the rr pointer, derived from
  // the behavioural rules; the queue holds {ch, data} of accepted words that
  // have not yet been handed to the sink.
  logic             m_known = 1'b0;
  logic             m_valid = 1'b0;
  logic [7:0]       m_data  = 8'h00;
  int               m_ch    = 0;
  int               m_ptr   = 0;
  logic [9:0]       exp_q[$];
  logic [3:0]       last_ir;

  // One clock cycle: drive inputs, check mid-cycle against the model,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic rr, input logic [1:0] s,
                       input logic [3:0] iv, input logic [31:0] d, input logic ordy);
    int         c;
    logic       hit;
    logic       can;
    logic [3:0] exp_ir;
    logic [9:0] got;
    rst = r; rr_mode = rr; sel = s; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    hit = 1'b0;
    c   = 0;
    if (!rr) begin
      if (int'(s) < N) begin
        hit = 1'b1;
        c   = int'(s);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!hit && iv[(m_ptr + k) % N]) begin
          hit = 1'b1;
          c   = (m_ptr + k) % N;
        end
      end
    end
    can    = !r && (!m_valid || ordy);
    exp_ir = (can && hit) ? 4'(1 << c) : 4'b0000;
    last_ir = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    if (m_known) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
      end
    end
    // Sink side of the scoreboard: every handshake must match an accepted word.
    if (!r && out_valid === 1'b1 && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'({out_ch, out_data}), 32'h3FF);
      end else begin
        got = exp_q.pop_front();
        check("sink_word", 32'({out_ch, out_data}), 32'(got));
      end
    end
    // Model next state.
    if (r) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ch    = 0;
      m_ptr   = 0;
      m_known = 1'b1;
      exp_q.delete();
    end else if (can && hit && iv[c]) begin
      m_valid = 1'b1;
      m_data  = d[c*8 +: 8];
      m_ch    = c;
      m_ptr   = (c + 1) % N;
      exp_q.push_back({2'(c), d[c*8 +: 8]});
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        rr;
    logic [1:0]  s;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  e_ir;   // in_ready during the cycle
    logic        e_ov;   // outputs after the edge
    logic [7:0]  e_od;
    logic [1:0]  e_och;
  } vec_t;

  vec_t vecs[16];

  initial begin
    rst = 1'b1; rr_mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset held two cycles with all inputs valid.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    // Explicit select of ch2, then sel=3 with only ch2 valid: no transfer.
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 2'd3, 4'b0100, 32'h00A50000, 1'b1, 4'b1000, 1'b0, 8'hA5, 2'd2};
    // Reset to bring ptr back to 0, then round-robin over four busy channels.
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // Explicit ch2 moves ptr to 3 (ptr carries across the mode change),
    // then sparse rr wrap: ch1, then ch3, then ch0.
    vecs[11] = '{1'b0, 1'b0, 2'd2, 4'b0100, 32'h33221100, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 4'b0010, 32'h33221100, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 4'b1001, 32'h33221100, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 4'b1001, 32'h33221100, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
    // No requester in rr mode: nothing chosen, register drains and holds data.
    vecs[15] = '{1'b0, 1'b1, 2'd0, 4'b0000, 32'h33221100, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    for (int v = 0; v < 16; v++) begin
      cycle(vecs[v].r, vecs[v].rr, vecs[v].s, vecs[v].iv, vecs[v].d, vecs[v].ordy);
      check($sformatf("vec%0d_in_ready", v), 32'(last_ir), 32'(vecs[v].e_ir));
      check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].e_ov));
      check($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vecs[v].e_od));
      check($sformatf("vec%0d_out_ch", v), 32'(out_ch), 32'(vecs[v].e_och));
    end

    // Back-pressure: load 0x3C from ch1 (ptr becomes 2), stall 5 cycles.
    cycle(1'b0, 1'b0, 2'd1, 4'b0010, 32'h00003C00, 1'b1);
    check("bp_load_data", 32'(out_data), 32'h3C);
    check("bp_load_ch", 32'(out_ch), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom, 1'b0);
      check("bp_stall_ready", 32'(last_ir), 32'h0);
      check("bp_stall_valid", 32'(out_valid), 32'h1);
      check("bp_stall_data", 32'(out_data), 32'h3C);
      check("bp_stall_ch", 32'(out_ch), 32'd1);
    end
    // Release: drain 0x3C and load ch2 (ptr still 2) in the same cycle.
    cycle(1'b0, 1'b1, 2'd0, 4'b1111, 32'h44332211, 1'b1);
    check("bp_resume_ready", 32'(last_ir), 32'b0100);
    check("bp_resume_valid", 32'(out_valid), 32'h1);
    check("bp_resume_data", 32'(out_data), 32'h33);

    // Reset during a stall discards the held word and zeroes ptr.
    cycle(1'b0, 1'b1, 2'd0, 4'b1111, 32'h44332211, 1'b0);
    check("rst_pre_valid", 32'(out_valid), 32'h1);
    cycle(1'b1, 1'b1, 2'd0, 4'b1111, 32'h44332211, 1'b0);
    check("rst_mid_ready", 32'(last_ir), 32'h0);
    check("rst_mid_valid", 32'(out_valid), 32'h0);
    check("rst_mid_data", 32'(out_data), 32'h0);
    cycle(1'b0, 1'b1, 2'd0, 4'b1111, 32'h44332211, 1'b1);
    check("rst_after_ready", 32'(last_ir), 32'b0001);
    check("rst_after_ch", 32'(out_ch), 32'd0);
    check("rst_after_data", 32'(out_data), 32'h11);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
